// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: field limits, widths and mode encoding.
package clock_pkg;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;

    // Mode encoding, also decoded by the display block for LEDs.
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_LOAD     = 2'd3
    } mode_e;

endpackage

// File: rtl/wrap_updown.sv
// Combinational up/down step of a modulo-(MAX+1) field, wrapping at 0 and MAX.
module wrap_updown #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    // inc and dec together cancel out and leave the field unchanged.
    always_comb begin
        nxt = cur;
        if (inc && !dec) begin
            nxt = (cur == MAX_V) ? '0 : cur + ONE_V;
        end else if (dec && !inc) begin
            nxt = (cur == '0) ? MAX_V : cur - ONE_V;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/setting controller: RUN -> SET_HOUR -> SET_MIN -> LOAD, with idle timeout and blink.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_1hz_en,
    input  logic              mode_pulse,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic              cancel_pulse,
    input  logic [HOUR_W-1:0] hour_cur,
    input  logic [MIN_W-1:0]  min_cur,
    output logic              time_count_en,
    output logic              load_en,
    output logic [HOUR_W-1:0] hour_set,
    output logic [MIN_W-1:0]  min_set,
    output logic              hour_blank,
    output logic              min_blank,
    output logic [1:0]        mode
);

    localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT_S - 1);

    mode_e             state, state_nx;
    logic [HOUR_W-1:0] hour_nx, hour_edit;
    logic [MIN_W-1:0]  min_nx, min_edit;
    logic [5:0]        idle_cnt, idle_nx;
    logic              blink_ph, blink_nx;

    wrap_updown #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour_wrap (
        .cur (hour_set),
        .inc (inc_pulse),
        .dec (dec_pulse),
        .nxt (hour_edit)
    );

    wrap_updown #(.W(MIN_W), .MAX(MIN_MAX)) u_min_wrap (
        .cur (min_set),
        .inc (inc_pulse),
        .dec (dec_pulse),
        .nxt (min_edit)
    );

    assign mode = state;

    // State and registered outputs; outputs are decoded from the next state so they align with mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= MODE_RUN;
            hour_set      <= '0;
            min_set       <= '0;
            idle_cnt      <= '0;
            blink_ph      <= 1'b1;
            time_count_en <= 1'b1;
            load_en       <= 1'b0;
            hour_blank    <= 1'b0;
            min_blank     <= 1'b0;
        end else begin
            state         <= state_nx;
            hour_set      <= hour_nx;
            min_set       <= min_nx;
            idle_cnt      <= idle_nx;
            blink_ph      <= blink_nx;
            time_count_en <= (state_nx == MODE_RUN);
            load_en       <= (state_nx == MODE_LOAD);
            hour_blank    <= (state_nx == MODE_SET_HOUR) && !blink_nx;
            min_blank     <= (state_nx == MODE_SET_MIN) && !blink_nx;
        end
    end

    // Next-state, field edits, idle timer and blink phase, in event priority order.
    always_comb begin
        state_nx = state;
        hour_nx  = hour_set;
        min_nx   = min_set;
        idle_nx  = idle_cnt;
        blink_nx = blink_ph;
        case (state)
            MODE_RUN: begin
                if (mode_pulse) begin
                    state_nx = MODE_SET_HOUR;
                    hour_nx  = hour_cur;
                    min_nx   = min_cur;
                    idle_nx  = '0;
                    blink_nx = 1'b1;
                end
            end
            MODE_SET_HOUR, MODE_SET_MIN: begin
                if (cancel_pulse) begin
                    state_nx = MODE_RUN;
                    idle_nx  = '0;
                end else if (mode_pulse) begin
                    idle_nx = '0;
                    if (state == MODE_SET_HOUR) begin
                        state_nx = MODE_SET_MIN;
                        blink_nx = 1'b1;
                    end else begin
                        state_nx = MODE_LOAD;
                    end
                end else if (clk_1hz_en && (idle_cnt == IDLE_LAST)) begin
                    // Abandon the edit; the counter resumes with its own time.
                    state_nx = MODE_RUN;
                    idle_nx  = '0;
                end else begin
                    if (inc_pulse || dec_pulse) begin
                        idle_nx = '0;
                        if (state == MODE_SET_HOUR) begin
                            hour_nx = hour_edit;
                        end else begin
                            min_nx = min_edit;
                        end
                    end else if (clk_1hz_en) begin
                        idle_nx = idle_cnt + 6'd1;
                    end
                    if (clk_1hz_en) begin
                        blink_nx = ~blink_ph;
                    end
                end
            end
            MODE_LOAD: begin
                state_nx = MODE_RUN;
            end
            default: begin
                state_nx = MODE_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a behavioural model pushes expected outputs per driven cycle.
module tb_time_set_ctrl;
    import clock_pkg::*;

    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_1hz_en, mode_pulse, inc_pulse, dec_pulse, cancel_pulse;
    logic [4:0] hour_cur;
    logic [5:0] min_cur;
    logic       time_count_en, load_en, hour_blank, min_blank;
    logic [4:0] hour_set;
    logic [5:0] min_set;
    logic [1:0] mode;

    always #5 clk = ~clk;

    time_set_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_1hz_en    (clk_1hz_en),
        .mode_pulse    (mode_pulse),
        .inc_pulse     (inc_pulse),
        .dec_pulse     (dec_pulse),
        .cancel_pulse  (cancel_pulse),
        .hour_cur      (hour_cur),
        .min_cur       (min_cur),
        .time_count_en (time_count_en),
        .load_en       (load_en),
        .hour_set      (hour_set),
        .min_set       (min_set),
        .hour_blank    (hour_blank),
        .min_blank     (min_blank),
        .mode          (mode)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic       tce;
        logic       ld;
        logic [4:0] hs;
        logic [5:0] ms;
        logic       hb;
        logic       mb;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   loads  = 0;

    // Behavioural model state
    int m_state, m_hour, m_min, m_idle, m_blink;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && load_en) loads++;
    end

    function automatic exp_t model_out();
        exp_t e;
        e.mode = 2'(m_state);
        e.tce  = (m_state == 0);
        e.ld   = (m_state == 3);
        e.hs   = 5'(m_hour);
        e.ms   = 6'(m_min);
        e.hb   = (m_state == 1) && (m_blink == 0);
        e.mb   = (m_state == 2) && (m_blink == 0);
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_hour = 0; m_min = 0; m_idle = 0; m_blink = 1;
    endtask

    task automatic model_step(input logic mp, ip, dp, cp, tk);
        if (m_state == 0) begin
            if (mp) begin
                m_hour = int'(hour_cur); m_min = int'(min_cur);
                m_state = 1; m_idle = 0; m_blink = 1;
            end
        end else if (m_state == 3) begin
            m_state = 0;
        end else begin
            if (cp) m_state = 0;
            else if (mp) begin
                if (m_state == 1) begin m_state = 2; m_blink = 1; end
                else m_state = 3;
                m_idle = 0;
            end else if (tk && m_idle == TO - 1) m_state = 0;
            else begin
                if (ip != dp) begin
                    if (m_state == 1) m_hour = (m_hour + (ip ? 1 : 23)) % 24;
                    else              m_min  = (m_min  + (ip ? 1 : 59)) % 60;
                end
                if (ip || dp) m_idle = 0;
                else if (tk) m_idle = m_idle + 1;
                if (tk) m_blink = 1 - m_blink;
            end
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("mode",          32'(mode),          32'(e.mode));
            check("time_count_en", 32'(time_count_en), 32'(e.tce));
            check("load_en",       32'(load_en),       32'(e.ld));
            check("hour_set",      32'(hour_set),      32'(e.hs));
            check("min_set",       32'(min_set),       32'(e.ms));
            check("hour_blank",    32'(hour_blank),    32'(e.hb));
            check("min_blank",     32'(min_blank),     32'(e.mb));
        end
    endtask

    // One clock of stimulus: drive, predict, then compare on the falling edge.
    task automatic cyc(input logic mp, ip, dp, cp, tk);
        mode_pulse = mp; inc_pulse = ip; dec_pulse = dp; cancel_pulse = cp; clk_1hz_en = tk;
        model_step(mp, ip, dp, cp, tk);
        sb_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        compare_pop();
        mode_pulse = 0; inc_pulse = 0; dec_pulse = 0; cancel_pulse = 0; clk_1hz_en = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, 32'(mode), 32'd0);
        check({tag, "_tce"},  32'(time_count_en), 32'd1);
        check({tag, "_load"}, 32'(load_en), 32'd0);
        check({tag, "_hour"}, 32'(hour_set), 32'd0);
        check({tag, "_min"},  32'(min_set), 32'd0);
        check({tag, "_hb"},   32'(hour_blank), 32'd0);
        check({tag, "_mb"},   32'(min_blank), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0;
        rst = 1; clk_1hz_en = 0; mode_pulse = 0; inc_pulse = 0; dec_pulse = 0; cancel_pulse = 0;
        hour_cur = 5'd12; min_cur = 6'd34;
        model_reset();
        #12;
        check_reset_vals("rst0");
        @(negedge clk); rst = 0;

        // Full edit: 12:34 -> 15:59 and load
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (35) cyc(0, 0, 1, 0, 0);
        l0 = loads;
        cyc(1, 0, 0, 0, 0);
        check("load_hour", 32'(hour_set), 32'd15);
        check("load_min",  32'(min_set), 32'd59);
        check("load_strobe", 32'(load_en), 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("post_load_tce", 32'(time_count_en), 32'd1);
        check("load_count", 32'(loads - l0), 32'd1);

        // Hour wrap and inc+dec together
        hour_cur = 5'd23; min_cur = 6'd0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); check("hour_wrap_up", 32'(hour_set), 32'd0);
        cyc(0, 0, 1, 0, 0); check("hour_wrap_dn", 32'(hour_set), 32'd23);
        cyc(0, 1, 1, 0, 0); check("hour_incdec", 32'(hour_set), 32'd23);
        cyc(0, 0, 0, 1, 0);

        // Timeout in SET_MIN, then deferred by an inc
        l0 = loads;
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 1);
            if (k == 1) check("to_before", 32'(mode), 32'd2);
        end
        check("to_run", 32'(mode), 32'd0);
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        check("to_deferred", 32'(mode), 32'd2);
        cyc(0, 0, 0, 0, 1);
        check("to_run2", 32'(mode), 32'd0);
        check("to_no_load", 32'(loads - l0), 32'd0);

        // Simultaneous events in SET_HOUR
        l0 = loads;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        check("cancel_wins", 32'(mode), 32'd0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("mode_wins", 32'(mode), 32'd2);
        check("mode_wins_hour", 32'(hour_set), 32'd23);
        cyc(0, 0, 0, 1, 0);
        check("cancel_no_load", 32'(loads - l0), 32'd0);

        // Blink in SET_HOUR
        cyc(1, 0, 0, 0, 0); check("blink0", 32'(hour_blank), 32'd0);
        cyc(0, 0, 0, 0, 1); check("blink1", 32'(hour_blank), 32'd1);
        check("blink1_min", 32'(min_blank), 32'd0);
        cyc(0, 0, 0, 0, 1); check("blink2", 32'(hour_blank), 32'd0);
        cyc(0, 0, 0, 1, 0);
        check("blink_run", 32'({hour_blank, min_blank}), 32'd0);

        // Randomised traffic through the scoreboard
        for (int i = 0; i < 400; i++) begin
            if (m_state == 0 && $urandom_range(0, 3) == 0) begin
                hour_cur = 5'($urandom_range(0, 23));
                min_cur  = 6'($urandom_range(0, 59));
            end
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0));
        end

        // Async reset mid-SET_MIN with hour_set = 7
        cyc(0, 0, 0, 1, 0);
        hour_cur = 5'd7; min_cur = 6'd20;
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        check("pre_rst_mode", 32'(mode), 32'd2);
        check("pre_rst_hour", 32'(hour_set), 32'd7);
        l0 = loads;
        #2 rst = 1;
        #1 check_reset_vals("rst_mid");
        model_reset();
        @(negedge clk); rst = 0;
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        check("rst_no_load", 32'(loads - l0), 32'd0);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Mode/setting controller for the clock's time_counter.
- Sequences RUN → SET_HOUR → SET_MIN → LOAD from single-cycle button pulses, already debounced and edge-detected upstream.
- Drives the counter's time_count_en, load_en, hour_in and min_in.
- Provides blink masks to the display block.
- Sits between the button conditioning logic and time_counter. It uses the same clk / clk_1hz_en timing domain.

Parameters:
TIMEOUT_S, 30, idle seconds in a SET state before the edit is abandoned without loading (legal range 2..63).

Ports:
clk  in  1  main system clock
rst  in  1  asynchronous, active-high reset
clk_1hz_en  in  1  one-clk-wide 1 Hz enable, shared with time_counter
mode_pulse  in  1  one-cycle pulse: advance to the next mode
inc_pulse  in  1  one-cycle pulse: increment the field being edited
dec_pulse  in  1  one-cycle pulse: decrement the field being edited
cancel_pulse  in  1  one-cycle pulse: abandon the edit
hour_cur  in  5  live hour from time_counter
min_cur  in  6  live minute from time_counter
time_count_en  out  1  counter run enable
load_en  out  1  one-cycle load strobe to time_counter
hour_set  out  5  edited hour; wired to time_counter hour_in
min_set  out  6  edited minute; wired to time_counter min_in
hour_blank  out  1  display blanks hour digits when 1
min_blank  out  1  display blanks minute digits when 1
mode  out  2  current state encoding, for LEDs and debug

Behaviour:
Outputs and reset:
- All outputs are registered.
- Reset values: state RUN, mode=0, time_count_en=1, load_en=0, hour_set=0, min_set=0, hour_blank=0, min_blank=0, idle_cnt=0, blink_ph=1.
- Reset asserted mid-edit returns to RUN with no load.

States (mode encoding):
- RUN (0): time_count_en=1. On mode_pulse at edge N, capture hour_cur→hour_set and min_cur→min_cur→min_set, then go to SET_HOUR. From N+1, time_count_en=0.
- The capture uses values sampled at edge N. A counter increment on that same edge is not reflected in the captured values. This is accepted.
- inc, dec and cancel pulses are ignored in RUN.
- SET_HOUR (1): time_count_en=0. Priority order, highest first:
  - cancel_pulse → RUN, no load.
  - mode_pulse → SET_MIN.
  - timeout → RUN, no load.
  - inc/dec edits hour_set.
- SET_MIN (2): same priority order as SET_HOUR, except mode_pulse → LOAD.
- LOAD (3): held for exactly one cycle.
  - load_en=1, time_count_en=0, hour_set/min_set stable.
  - Next cycle: RUN with load_en=0 and time_count_en=1.
  - All input pulses are ignored in LOAD.

Edit arithmetic (edited field only):
- inc wraps hour 23→0 and minute 59→0.
- dec wraps hour 0→23 and minute 0→59.
- inc and dec in the same cycle: no change, but idle_cnt still clears.
- The other field holds its value.

Idle timeout:
- idle_cnt width is 6 bits.
- Clears on entry to SET_HOUR or SET_MIN and on any inc or dec pulse.
- Increments on clk_1hz_en while in a SET state.
- If clk_1hz_en=1 and idle_cnt==TIMEOUT_S-1 with no higher-priority event that cycle, go to RUN without loading. The counter resumes with its untouched time.

Blink:
- blink_ph is set to 1 on entry to any SET state and toggles on each clk_1hz_en while in that state.
- hour_blank = (state==SET_HOUR) & ~blink_ph.
- min_blank = (state==SET_MIN) & ~blink_ph.
- Both blank outputs are 0 in RUN and LOAD.

Simultaneous events:
- mode_pulse together with inc/dec: the mode transition wins and the edit is dropped.
- clk_1hz_en in the same cycle as the LOAD→RUN transition: no special handling. time_counter's load priority covers the LOAD cycle.

Decomposition:
Shared package clock_pkg:
- HOUR_MAX=23 and MIN_MAX=59.
- Mode encodings MODE_RUN=0, MODE_SET_HOUR=1, MODE_SET_MIN=2, MODE_LOAD=3.
- The package is also used by the display block to decode mode.

Sub-module wrap_updown:
- Parameterised width and max; one instance per field.
- Combinational next value from (cur, inc, dec), with wrap at 0 and max.
- The FSM, idle timer and blink logic stay in the top module.

Test Plan:
- Reset mid-SET_MIN with hour_set=7 → all outputs at reset values, mode=0, time_count_en=1, no load_en pulse.
- RUN with hour_cur=12, min_cur=34; mode_pulse; inc ×3; mode_pulse; dec ×35; mode_pulse → exactly one load_en cycle with hour_set=15, min_set=59 (34−35 wraps to 59); time_count_en=1 the following cycle.
- SET_HOUR with hour_set=23: inc → 0. Then dec → 23. inc and dec in the same cycle → 23 unchanged.
- SET_MIN, TIMEOUT_S=3, no pulses → RUN after the 3rd clk_1hz_en; load_en never asserted. Repeat with inc before the 3rd clk_1hz_en → timeout deferred by a full 3 s.
- cancel_pulse and mode_pulse in the same cycle in SET_HOUR → RUN, no load. mode_pulse with inc in SET_HOUR → SET_MIN, hour_set unchanged.
- Blink check: enter SET_HOUR → hour_blank=0, then 1 after the 1st clk_1hz_en, 0 after the 2nd; min_blank=0 throughout; both 0 in RUN.
